// File: rtl/vga_frame_sync_if.sv
// Bundle between the register file, the frame synchroniser and the renderer.
// Carries pending values, the commit handshake, shadowed values and VGA timing.
interface vga_frame_sync_if;
    // Handshake: commit_req is a single-cycle request to adopt the pending
    // values at the next frame boundary. There is no ready/back-pressure.
    // commit_ack pulses for exactly one cycle after the edge that committed.
    logic [15:0] xPillar1_in;
    logic [15:0] xPillar2_in;
    logic [15:0] xPillar3_in;
    logic [7:0]  hPillar1_in;
    logic [7:0]  hPillar2_in;
    logic [7:0]  hPillar3_in;
    logic [15:0] score_in;
    logic [15:0] bird_in;
    logic        start_in;
    logic        commit_req;

    logic [15:0] xPillar1;
    logic [15:0] xPillar2;
    logic [15:0] xPillar3;
    logic [7:0]  hPillar1;
    logic [7:0]  hPillar2;
    logic [7:0]  hPillar3;
    logic [15:0] score;
    logic [15:0] bird;
    logic        start;

    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        VGA_CLK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_n;
    logic        VGA_SYNC_n;
    logic        commit_ack;
    logic [15:0] frame_count;
    logic        pending;

    modport master (
        output xPillar1_in, xPillar2_in, xPillar3_in,
        output hPillar1_in, hPillar2_in, hPillar3_in,
        output score_in, bird_in, start_in, commit_req,
        input  xPillar1, xPillar2, xPillar3, hPillar1, hPillar2, hPillar3,
        input  score, bird, start,
        input  hcount, vcount, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n,
        input  commit_ack, frame_count, pending
    );

    modport slave (
        input  xPillar1_in, xPillar2_in, xPillar3_in,
        input  hPillar1_in, hPillar2_in, hPillar3_in,
        input  score_in, bird_in, start_in, commit_req,
        output xPillar1, xPillar2, xPillar3, hPillar1, hPillar2, hPillar3,
        output score, bird, start,
        output hcount, vcount, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n,
        output commit_ack, frame_count, pending
    );
endinterface

// File: rtl/vga_frame_sync.sv
// VGA timing generator with frame-synchronous shadow registers: renderer-facing
// values only change on the last cycle of the last visible line.
module vga_frame_sync #(
    parameter bit AUTO_COMMIT  = 1'b0,
    parameter int H_TOTAL      = 1600,
    parameter int H_ACTIVE     = 1280,
    parameter int H_SYNC_START = 1312,
    parameter int H_SYNC_END   = 1503,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 491
) (
    input logic             clk,
    input logic             reset,
    vga_frame_sync_if.slave bus
);

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_SYNC_START);
    localparam logic [10:0] HS_LAST  = 11'(H_SYNC_END);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_FIRST = 10'(V_SYNC_START);
    localparam logic [9:0]  VS_LAST  = 10'(V_SYNC_END);
    localparam logic [9:0]  FB_LINE  = 10'(V_ACTIVE - 1);

    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        line_end;
    logic        frame_boundary;
    logic        commit;
    logic        pending;
    logic        commit_ack;
    logic [15:0] frame_count;

    logic [15:0] x1_q, x2_q, x3_q;
    logic [7:0]  h1_q, h2_q, h3_q;
    logic [15:0] score_q, bird_q;
    logic        start_q;

    always_comb begin
        line_end       = (hcount == H_LAST);
        frame_boundary = line_end && (vcount == FB_LINE);
        // A request on the boundary cycle itself commits immediately.
        commit         = frame_boundary && (pending || bus.commit_req || AUTO_COMMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (line_end) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 11'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (frame_boundary) begin
            pending <= 1'b0;
        end else if (bus.commit_req) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_ack  <= 1'b0;
            frame_count <= '0;
        end else begin
            commit_ack <= commit;
            if (frame_boundary) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // All shadows load on one enable so the renderer never sees a mixed set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x1_q    <= 16'd50;
            x2_q    <= 16'd300;
            x3_q    <= 16'd600;
            h1_q    <= 8'd10;
            h2_q    <= 8'd15;
            h3_q    <= 8'd20;
            score_q <= 16'h0888;
            bird_q  <= 16'd200;
            start_q <= 1'b0;
        end else if (commit) begin
            x1_q    <= bus.xPillar1_in;
            x2_q    <= bus.xPillar2_in;
            x3_q    <= bus.xPillar3_in;
            h1_q    <= bus.hPillar1_in;
            h2_q    <= bus.hPillar2_in;
            h3_q    <= bus.hPillar3_in;
            score_q <= bus.score_in;
            bird_q  <= bus.bird_in;
            start_q <= bus.start_in;
        end
    end

    assign bus.xPillar1    = x1_q;
    assign bus.xPillar2    = x2_q;
    assign bus.xPillar3    = x3_q;
    assign bus.hPillar1    = h1_q;
    assign bus.hPillar2    = h2_q;
    assign bus.hPillar3    = h3_q;
    assign bus.score       = score_q;
    assign bus.bird        = bird_q;
    assign bus.start       = start_q;

    assign bus.hcount      = hcount;
    assign bus.vcount      = vcount;
    assign bus.VGA_CLK     = hcount[0];
    assign bus.VGA_HS      = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
    assign bus.VGA_VS      = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
    assign bus.VGA_BLANK_n = (hcount < H_ACT) && (vcount < V_ACT);
    assign bus.VGA_SYNC_n  = 1'b1;
    assign bus.commit_ack  = commit_ack;
    assign bus.frame_count = frame_count;
    assign bus.pending     = pending;

endmodule

// File: tb/tb_vga_frame_sync.sv
// Bench for vga_frame_sync: scaled-geometry instances (manual and auto commit)
// against an arithmetic frame model, plus a full-geometry timing instance.
module tb_vga_frame_sync;

    localparam int HT  = 40;
    localparam int HA  = 32;
    localparam int HSS = 33;
    localparam int HSE = 36;
    localparam int VT  = 14;
    localparam int VA  = 10;
    localparam int VSS = 11;
    localparam int VSE = 12;
    localparam int FRAME = HT * VT;

    typedef logic [104:0] shadow_t;
    localparam shadow_t RESET_SHADOW = {16'd50, 16'd300, 16'd600, 8'd10, 8'd15, 8'd20,
                                        16'h0888, 16'd200, 1'b0};

    typedef struct {
        int   cyc;
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic blank;
    } vec_t;

    logic    clk = 1'b0;
    logic    reset = 1'b1;
    shadow_t in_vec = RESET_SHADOW;
    logic    req = 1'b0;
    int      checks = 0;
    int      failures = 0;

    // Reference model state
    int          t;
    shadow_t     exp_sh [2];
    logic        ack_m  [2];
    logic        pend_m;
    logic [15:0] frames_m;

    always #5 clk = ~clk;

    vga_frame_sync_if sd ();
    vga_frame_sync_if sa ();
    vga_frame_sync_if sf ();

    vga_frame_sync #(
        .AUTO_COMMIT(1'b0), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
    ) u_dut (.clk(clk), .reset(reset), .bus(sd.slave));

    vga_frame_sync #(
        .AUTO_COMMIT(1'b1), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
    ) u_auto (.clk(clk), .reset(reset), .bus(sa.slave));

    vga_frame_sync u_full (.clk(clk), .reset(reset), .bus(sf.slave));

    assign {sd.xPillar1_in, sd.xPillar2_in, sd.xPillar3_in, sd.hPillar1_in, sd.hPillar2_in,
            sd.hPillar3_in, sd.score_in, sd.bird_in, sd.start_in} = in_vec;
    assign {sa.xPillar1_in, sa.xPillar2_in, sa.xPillar3_in, sa.hPillar1_in, sa.hPillar2_in,
            sa.hPillar3_in, sa.score_in, sa.bird_in, sa.start_in} = in_vec;
    assign {sf.xPillar1_in, sf.xPillar2_in, sf.xPillar3_in, sf.hPillar1_in, sf.hPillar2_in,
            sf.hPillar3_in, sf.score_in, sf.bird_in, sf.start_in} = 105'd0;
    assign sd.commit_req = req;
    assign sa.commit_req = req;
    assign sf.commit_req = 1'b0;

    shadow_t sd_sh, sa_sh;
    assign sd_sh = {sd.xPillar1, sd.xPillar2, sd.xPillar3, sd.hPillar1, sd.hPillar2,
                    sd.hPillar3, sd.score, sd.bird, sd.start};
    assign sa_sh = {sa.xPillar1, sa.xPillar2, sa.xPillar3, sa.hPillar1, sa.hPillar2,
                    sa.hPillar3, sa.score, sa.bird, sa.start};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0d", name, act, exp, t);
        end
    endtask

    task automatic check_inst(input string tag, input int k,
                              input logic [10:0] hc, input logic [9:0] vc,
                              input logic hs, input logic vs, input logic bl,
                              input logic vclk, input logic syncn, input shadow_t sh,
                              input logic ack, input logic [15:0] fc, input logic pend);
        int h, v;
        h = t % HT;
        v = (t / HT) % VT;
        chk({tag, "_hcount"}, hc, h);
        chk({tag, "_vcount"}, vc, v);
        chk({tag, "_hs"}, hs, !(h >= HSS && h <= HSE));
        chk({tag, "_vs"}, vs, !(v >= VSS && v <= VSE));
        chk({tag, "_blank_n"}, bl, (h < HA) && (v < VA));
        chk({tag, "_vga_clk"}, vclk, h % 2);
        chk({tag, "_sync_n"}, syncn, 1'b1);
        chk({tag, "_shadow"}, sh, exp_sh[k]);
        chk({tag, "_commit_ack"}, ack, ack_m[k]);
        chk({tag, "_frame_count"}, fc, frames_m);
        chk({tag, "_pending"}, pend, pend_m);
    endtask

    // Compare both scaled instances, advance the model one clock, wait one clock.
    task automatic step();
        int  h, v;
        logic c;
        check_inst("dut", 0, sd.hcount, sd.vcount, sd.VGA_HS, sd.VGA_VS, sd.VGA_BLANK_n,
                   sd.VGA_CLK, sd.VGA_SYNC_n, sd_sh, sd.commit_ack, sd.frame_count, sd.pending);
        check_inst("auto", 1, sa.hcount, sa.vcount, sa.VGA_HS, sa.VGA_VS, sa.VGA_BLANK_n,
                   sa.VGA_CLK, sa.VGA_SYNC_n, sa_sh, sa.commit_ack, sa.frame_count, sa.pending);
        h = t % HT;
        v = (t / HT) % VT;
        if (h == HT - 1 && v == VA - 1) begin
            frames_m = frames_m + 16'd1;
            for (int k = 0; k < 2; k++) begin
                c = pend_m || req || (k == 1);
                if (c) exp_sh[k] = in_vec;
                ack_m[k] = c;
            end
            pend_m = 1'b0;
        end else begin
            if (req) pend_m = 1'b1;
            ack_m[0] = 1'b0;
            ack_m[1] = 1'b0;
        end
        @(negedge clk);
        t++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 1'b0;
        @(negedge clk);
        chk("rst_hcount", sd.hcount, 11'd0);
        chk("rst_vcount", sd.vcount, 10'd0);
        chk("rst_pending", sd.pending, 1'b0);
        chk("rst_commit_ack", sd.commit_ack, 1'b0);
        chk("rst_frame_count", sd.frame_count, 16'd0);
        chk("rst_shadow", sd_sh, RESET_SHADOW);
        chk("rst_auto_shadow", sa_sh, RESET_SHADOW);
        chk("rst_full_hcount", sf.hcount, 11'd0);
        reset    = 1'b0;
        t        = 0;
        pend_m   = 1'b0;
        frames_m = 16'd0;
        for (int k = 0; k < 2; k++) begin
            exp_sh[k] = RESET_SHADOW;
            ack_m[k]  = 1'b0;
        end
    endtask

    vec_t vecs [15];

    initial begin
        int hs_low, blank_hi;

        vecs[0]  = '{0,   0,  0,  1'b1, 1'b1, 1'b1};
        vecs[1]  = '{31,  31, 0,  1'b1, 1'b1, 1'b1};
        vecs[2]  = '{32,  32, 0,  1'b1, 1'b1, 1'b0};
        vecs[3]  = '{33,  33, 0,  1'b0, 1'b1, 1'b0};
        vecs[4]  = '{36,  36, 0,  1'b0, 1'b1, 1'b0};
        vecs[5]  = '{37,  37, 0,  1'b1, 1'b1, 1'b0};
        vecs[6]  = '{40,  0,  1,  1'b1, 1'b1, 1'b1};
        vecs[7]  = '{399, 39, 9,  1'b1, 1'b1, 1'b0};
        vecs[8]  = '{400, 0,  10, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{440, 0,  11, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{473, 33, 11, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{519, 39, 12, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{520, 0,  13, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{559, 39, 13, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{560, 0,  0,  1'b1, 1'b1, 1'b1};

        @(negedge clk);

        // Timing decode table
        for (int i = 0; i < 15; i++) begin
            do_reset();
            repeat (vecs[i].cyc) @(negedge clk);
            chk("tbl_hcount", sd.hcount, vecs[i].h);
            chk("tbl_vcount", sd.vcount, vecs[i].v);
            chk("tbl_hs", sd.VGA_HS, vecs[i].hs);
            chk("tbl_vs", sd.VGA_VS, vecs[i].vs);
            chk("tbl_blank_n", sd.VGA_BLANK_n, vecs[i].blank);
        end

        // Request mid-frame, commit at boundary, no recommit without request
        in_vec = RESET_SHADOW;
        do_reset();
        while (t < 60) step();
        in_vec[16:1] = 16'd300;
        req = 1'b1;
        step();
        req = 1'b0;
        while (t < HT * VA - 1) step();
        chk("seq_bird_before_fb", sd.bird, 16'd200);
        step();
        chk("seq_bird_after_fb", sd.bird, 16'd300);
        chk("seq_ack_pulse", sd.commit_ack, 1'b1);
        step();
        chk("seq_ack_drop", sd.commit_ack, 1'b0);
        in_vec[16:1] = 16'd400;
        while (t < HT * VA + FRAME) step();
        chk("seq_bird_no_recommit", sd.bird, 16'd300);
        chk("seq_frames_two", sd.frame_count, 16'd2);

        // Request on the boundary cycle itself
        while (t < HT * VA - 1 + 2 * FRAME) step();
        in_vec[104:89] = 16'h0123;
        req = 1'b1;
        step();
        req = 1'b0;
        chk("seq_fb_req_x1", sd.xPillar1, 16'h0123);
        chk("seq_fb_req_ack", sd.commit_ack, 1'b1);
        chk("seq_fb_req_no_pending", sd.pending, 1'b0);
        while (t < HT * VA + 3 * FRAME) step();
        chk("seq_fb_next_ack", sd.commit_ack, 1'b0);

        // Reset discards a pending request
        do_reset();
        in_vec[16:1] = 16'd999;
        while (t < 50) step();
        req = 1'b1;
        step();
        req = 1'b0;
        while (t < 100) step();
        chk("seq_pending_set", sd.pending, 1'b1);
        do_reset();
        while (t < HT * VA) step();
        chk("seq_rst_shadow", sd_sh, RESET_SHADOW);
        chk("seq_rst_ack", sd.commit_ack, 1'b0);
        chk("seq_rst_frames", sd.frame_count, 16'd1);

        // Randomised run against the model
        do_reset();
        for (int i = 0; i < 4 * FRAME; i++) begin
            if ($urandom_range(0, 19) == 0)
                in_vec = shadow_t'({$urandom(), $urandom(), $urandom(), $urandom()});
            req = ($urandom_range(0, 299) == 0);
            step();
        end
        req = 1'b0;

        // Full 640x480 geometry over two lines
        do_reset();
        hs_low   = 0;
        blank_hi = 0;
        for (int i = 0; i < 3200; i++) begin
            chk("full_hcount", sf.hcount, i % 1600);
            chk("full_vga_clk", sf.VGA_CLK, i % 2);
            if (!sf.VGA_HS) hs_low++;
            if (sf.VGA_BLANK_n) blank_hi++;
            @(negedge clk);
        end
        chk("full_hs_low", hs_low, 384);
        chk("full_blank_hi", blank_hi, 2560);
        chk("full_vcount", sf.vcount, 10'd2);
        chk("full_vs", sf.VGA_VS, 1'b1);
        chk("full_sync_n", sf.VGA_SYNC_n, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
